// File: rtl/sequential_signed_divider.sv
// -----------------------------------------------------------------------------
// sequential_signed_divider
//
// Multi-cycle signed integer divider. It converts both operands to
// sign-magnitude form, runs a restoring division that produces one quotient bit
// per clock, and then puts the signs back. Quotient and remainder follow
// C semantics: the quotient truncates toward zero and the remainder takes the
// sign of the dividend.
//
// Parameters:
//   DIVIDEND_W  dividend width; also the magnitude width and the iteration count
//   DIVISOR_W   divisor width; also the quotient and remainder width
//
// Ports:
//   clk          in   clock; all state changes on the rising edge
//   rst          in   synchronous active-high reset; aborts any operation
//   start        in   request; sampled only while idle
//   dividend     in   signed dividend, captured when start is accepted
//   divisor      in   signed divisor, captured when start is accepted
//   busy         out  high from the edge after accept until done is raised
//   done         out  one-cycle pulse; the result outputs are valid
//   quotient     out  signed quotient, held until the next result
//   remainder    out  signed remainder, held until the next result
//   overflow     out  true quotient does not fit in DIVISOR_W signed bits
//   div_by_zero  out  divisor was zero (quotient/remainder forced to 0)
//
// Optional feature (macro DIV_SATURATE_EN):
//   defined   - an overflowing quotient saturates to +max / -min
//   undefined - an overflowing quotient is the low DIVISOR_W bits of the
//               signed truncated quotient
//   overflow is flagged in both builds, and the remainder is never affected.
// -----------------------------------------------------------------------------
module sequential_signed_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  // These are the limits on the quotient magnitude for each result sign.
  localparam logic [DIVIDEND_W-1:0] Q_POS_LIM = DIVIDEND_W'((1 << (DIVISOR_W - 1)) - 1);
  localparam logic [DIVIDEND_W-1:0] Q_NEG_LIM = DIVIDEND_W'(1 << (DIVISOR_W - 1));
  localparam logic [DIVISOR_W-1:0]  SAT_POS   = {1'b0, {(DIVISOR_W - 1){1'b1}}};
  localparam logic [DIVISOR_W-1:0]  SAT_NEG   = {1'b1, {(DIVISOR_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_SIGN
  } state_t;

  state_t                 state_q, state_d;
  logic                   qneg_q, qneg_d;      // quotient is negative
  logic                   rneg_q, rneg_d;      // remainder is negative
  logic                   dbz_q, dbz_d;        // captured divisor was zero
  logic                   pad_q, pad_d;        // divide-by-zero settle cycle used
  logic [DIVIDEND_W-1:0]  dvd_q, dvd_d;        // dividend magnitude, shifted MSB first
  logic [DIVISOR_W-1:0]   dsr_q, dsr_d;        // divisor magnitude (128 fits unsigned)
  logic [DIVISOR_W:0]     prem_q, prem_d;      // partial remainder
  logic [DIVIDEND_W-1:0]  qmag_q, qmag_d;      // quotient magnitude
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [DIVISOR_W-1:0]   quot_q, quot_d;
  logic [DIVISOR_W-1:0]   rem_q, rem_d;
  logic                   ovf_q, ovf_d;
  logic                   dbzo_q, dbzo_d;

  // ---------------------------------------------------------------------------
  // Restoring-division step. The trial value is one bit wider than the
  // partial remainder, so the compare sees the true shifted value.
  // ---------------------------------------------------------------------------
  logic [DIVISOR_W+1:0] trial_w;
  logic [DIVISOR_W+1:0] dsr_ext_w;
  logic                 take_w;

  assign trial_w   = {prem_q, dvd_q[DIVIDEND_W-1]};
  assign dsr_ext_w = {2'b00, dsr_q};
  assign take_w    = (trial_w >= dsr_ext_w);

  // ---------------------------------------------------------------------------
  // Sign application. The low bits of a two's-complement negation depend only
  // on the low bits of the operand. So the truncated signed quotient can be
  // built from the low DIVISOR_W bits of the magnitude alone.
  // ---------------------------------------------------------------------------
  logic [DIVISOR_W-1:0] qlow_w;
  logic [DIVISOR_W-1:0] q_trunc_w;
  logic [DIVISOR_W-1:0] q_out_w;
  logic                 q_ovf_w;
  logic [DIVISOR_W-1:0] rmag_w;
  logic [DIVISOR_W-1:0] r_out_w;

  assign qlow_w    = qmag_q[DIVISOR_W-1:0];
  assign q_trunc_w = qneg_q ? (DIVISOR_W'(0) - qlow_w) : qlow_w;
  assign q_ovf_w   = qneg_q ? (qmag_q > Q_NEG_LIM) : (qmag_q > Q_POS_LIM);
  assign rmag_w    = prem_q[DIVISOR_W-1:0];
  assign r_out_w   = rneg_q ? (DIVISOR_W'(0) - rmag_w) : rmag_w;

`ifdef DIV_SATURATE_EN
  assign q_out_w = q_ovf_w ? (qneg_q ? SAT_NEG : SAT_POS) : q_trunc_w;
`else
  assign q_out_w = q_trunc_w;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    pad_d   = pad_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    prem_d  = prem_q;
    qmag_d  = qmag_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbzo_d  = dbzo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          qneg_d  = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
          rneg_d  = dividend[DIVIDEND_W-1];
          dvd_d   = dividend[DIVIDEND_W-1] ? (DIVIDEND_W'(0) - dividend) : dividend;
          dsr_d   = divisor[DIVISOR_W-1] ? (DIVISOR_W'(0) - divisor) : divisor;
          prem_d  = '0;
          qmag_d  = '0;
          count_d = '0;
          pad_d   = 1'b0;
          busy_d  = 1'b1;
          dbz_d   = (divisor == '0);
          state_d = (divisor == '0) ? S_SIGN : S_DIVIDE;
        end
      end

      S_DIVIDE: begin
        prem_d  = take_w ? (DIVISOR_W+1)'(trial_w - dsr_ext_w) : trial_w[DIVISOR_W:0];
        qmag_d  = {qmag_q[DIVIDEND_W-2:0], take_w};
        dvd_d   = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(DIVIDEND_W - 1)) begin
          state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        // A divide by zero spends one extra cycle here. This gives it a fixed
        // two-edge turnaround from accept to done.
        if (dbz_q && !pad_q) begin
          pad_d = 1'b1;
        end else begin
          if (dbz_q) begin
            quot_d = '0;
            rem_d  = '0;
            ovf_d  = 1'b0;
          end else begin
            quot_d = q_out_w;
            rem_d  = r_out_w;
            ovf_d  = q_ovf_w;
          end
          dbzo_d  = dbz_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      pad_q   <= 1'b0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      qmag_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbzo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      pad_q   <= pad_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      qmag_q  <= qmag_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbzo_q  <= dbzo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbzo_q;

endmodule

// File: tb/tb_sequential_signed_divider.sv
// -----------------------------------------------------------------------------
// Testbench for sequential_signed_divider. The reference model uses plain
// integer division (C semantics). Each table entry also carries hand-computed
// literal results, which pin down the model itself.
// -----------------------------------------------------------------------------
module tb_sequential_signed_divider;

  localparam int DW = 16;
  localparam int SW = 8;
`ifdef DIV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [SW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          overflow;
  logic          div_by_zero;

  sequential_signed_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expectations for the operation in flight
  logic          pending = 1'b0;
  logic          seen    = 1'b0;
  int            cyc     = 0;
  int            exp_lat;
  logic [SW-1:0] exp_q, exp_r;
  logic          exp_ovf, exp_dbz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: C-style signed division on plain integers.
  function automatic void model(input logic [DW-1:0] a, input logic [SW-1:0] b);
    int          ai;
    int          bi;
    int          qt;
    int          rt;
    logic [31:0] qv;
    logic [31:0] rv;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      exp_q   = '0;
      exp_r   = '0;
      exp_ovf = 1'b0;
      exp_dbz = 1'b1;
      exp_lat = 3;
    end else begin
      qt      = ai / bi;
      rt      = ai % bi;
      qv      = qt;
      rv      = rt;
      exp_ovf = (qt > 127) || (qt < -128);
      exp_q   = qv[SW-1:0];
      if (exp_ovf && SAT) exp_q = (qt > 0) ? 8'h7F : 8'h80;
      exp_r   = rv[SW-1:0];
      exp_dbz = 1'b0;
      exp_lat = 18;
    end
  endfunction

  // Compare process. It runs on every falling edge. While an operation is in
  // flight it checks busy. When done pulses it checks the latency and the
  // result. A done pulse with nothing in flight is an error.
  always @(negedge clk) begin
    if (pending) begin
      cyc = cyc + 1;
      if (done) begin
        check("latency",   cyc,         exp_lat);
        check("busy_done", busy,        1'b0);
        check("quotient",  quotient,    exp_q);
        check("remainder", remainder,   exp_r);
        check("overflow",  overflow,    exp_ovf);
        check("dbz",       div_by_zero, exp_dbz);
        $display("op done: cyc=%0d q=0x%02h r=0x%02h ovf=%0b dbz=%0b", cyc, quotient,
                 remainder, overflow, div_by_zero);
        pending = 1'b0;
        seen    = 1'b1;
      end else begin
        check("busy", busy, 1'b1);
      end
    end else if (done) begin
      check("spurious_done", done, 1'b0);
    end
  end

  typedef struct {
    logic [DW-1:0] a;
    logic [SW-1:0] b;
    logic [SW-1:0] q;
    logic [SW-1:0] r;
    logic          ovf;
    logic          dbz;
    bit            poke;
  } vec_t;

  vec_t vecs [16];

  task automatic launch(input logic [DW-1:0] a, input logic [SW-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    model(a, b);
    @(posedge clk);
    #1;
    start    = 1'b0;
    cyc      = 0;
    seen     = 1'b0;
    pending  = 1'b1;
    // The operands may change freely once the request has been accepted.
    dividend = DW'($urandom);
    divisor  = SW'($urandom);
  endtask

  task automatic do_op(input vec_t v);
    launch(v.a, v.b);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (seen) break;
      if (v.poke && (i == 3 || i == 9)) begin
        // This start arrives while busy and carries different operands.
        #1;
        dividend = 16'd77;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: done not seen for a=%0d b=%0d", $signed(v.a), $signed(v.b));
      pending = 1'b0;
    end
    #1;
    check("done_pulse", done,        1'b0);
    check("lit_q",      quotient,    v.q);
    check("lit_r",      remainder,   v.r);
    check("lit_ovf",    overflow,    v.ovf);
    check("lit_dbz",    div_by_zero, v.dbz);
    $display("op %0d / %0d -> q=0x%02h r=0x%02h ovf=%0b dbz=%0b", $signed(v.a), $signed(v.b),
             quotient, remainder, overflow, div_by_zero);
  endtask

  initial begin
    vecs[0]  = '{16'd1000,      8'd10,       8'h64, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'(-1000),    8'd10,       8'h9C, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'(-1280),    8'd10,       8'h80, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'(-7),       8'd2,        8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'd7,         8'(-2),      8'hFD, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'(-7),       8'(-2),      8'h03, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'd32767,     8'd1,        SAT ? 8'h7F : 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{16'h8000,      8'h80,       SAT ? 8'h7F : 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{16'd1234,      8'd0,        8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{16'd1000,      8'd10,       8'h64, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'd32767,     8'd127,      SAT ? 8'h7F : 8'h02, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{16'h8000,      8'd1,        SAT ? 8'h80 : 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{16'(-300),     8'd7,        8'hD6, 8'hFA, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{16'd100,       8'h80,       8'h00, 8'h64, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{16'd127,       8'h80,       8'h00, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{16'd500,       8'(-5),      8'h9C, 8'h00, 1'b0, 1'b0, 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy,        1'b0);
    check("rst_done", done,        1'b0);
    check("rst_q",    quotient,    8'h00);
    check("rst_r",    remainder,   8'h00);
    check("rst_ovf",  overflow,    1'b0);
    check("rst_dbz",  div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) do_op(vecs[i]);

    // Abort mid-operation. The last result above is nonzero, so the reset
    // clearing the outputs is observable.
    launch(16'd5000, 8'd7);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst     = 1'b1;
    pending = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", busy,        1'b0);
    check("abort_done", done,        1'b0);
    check("abort_q",    quotient,    8'h00);
    check("abort_r",    remainder,   8'h00);
    check("abort_ovf",  overflow,    1'b0);
    check("abort_dbz",  div_by_zero, 1'b0);
    $display("abort: busy=%0b q=0x%02h r=0x%02h", busy, quotient, remainder);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);   // the compare process flags any stray done

    do_op('{16'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
